// File: rtl/dilithium_pkg.sv
// Shared constants for the Dilithium sampling datapath: SHAKE rates, the
// squeeze-stream FSM encoding and the SampleInBall tau/level parameters.
package dilithium_pkg;

    localparam int SHAKE128_RATE_BYTES = 168;
    localparam int SHAKE256_RATE_BYTES = 136;

    // Squeeze byte-stream FSM encoding, kept as plain constants for older tools
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // SampleInBall: first bytes of the stream are sign bits, the rest are candidates
    localparam int SIGN_BYTES  = 8;
    localparam int TAU_LEVEL2  = 39;
    localparam int TAU_LEVEL3  = 49;
    localparam int TAU_LEVEL5  = 60;

    function automatic int tau_for_level(input int level);
        case (level)
            2:       return TAU_LEVEL2;
            3:       return TAU_LEVEL3;
            default: return TAU_LEVEL5;
        endcase
    endfunction

endpackage

// File: rtl/squeeze_block_slot.sv
// One rate-block holding register with a valid flag; load wins over clear so a
// block can be dropped in and the old contents retired on the same edge.
module squeeze_block_slot
    import dilithium_pkg::*;
#(
    parameter int RATE_BYTES = SHAKE256_RATE_BYTES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    clear,
    input  logic [RATE_BYTES*8-1:0] din,
    output logic [RATE_BYTES*8-1:0] dout,
    output logic                    valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/shake_squeeze_byte_stream.sv
// Turns SHAKE squeeze rate blocks into a one-byte-per-cycle valid/ready stream,
// prefetching one block so block boundaries cost no bubble.
module shake_squeeze_byte_stream
    import dilithium_pkg::*;
#(
    parameter int RATE_BYTES = SHAKE256_RATE_BYTES,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    output logic                    squeeze_req,
    input  logic                    blk_valid,
    output logic                    blk_ready,
    input  logic [RATE_BYTES*8-1:0] blk_data,
    output logic                    byte_valid,
    input  logic                    byte_ready,
    output logic [7:0]              byte_data,
    output logic                    busy,
    output logic [CNT_W-1:0]        byte_count
);

    localparam int PTR_W = $clog2(RATE_BYTES);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RATE_BYTES - 1);

    logic [1:0]              state;
    logic                    pend;
    logic [PTR_W-1:0]        ptr;
    logic [PTR_W+2:0]        bit_idx;

    logic [RATE_BYTES*8-1:0] cur_data;
    logic [RATE_BYTES*8-1:0] nxt_data;
    logic [RATE_BYTES*8-1:0] cur_din;
    logic                    cur_v;
    logic                    nxt_v;
    logic                    cur_load;
    logic                    cur_clear;
    logic                    nxt_load;
    logic                    nxt_clear;

    logic                    in_run;
    logic                    start_idle;
    logic                    stop_run;
    logic                    byte_hs;
    logic                    wrap;
    logic                    blk_acc;
    logic                    cur_after_v;

    assign in_run     = (state == ST_RUN);
    assign start_idle = (state == ST_IDLE) & start;
    assign stop_run   = in_run & stop;
    assign busy       = (state != ST_IDLE);

    assign byte_valid = cur_v;
    assign bit_idx    = {ptr, 3'b000};
    assign byte_data  = cur_data[bit_idx +: 8];

    assign byte_hs = cur_v & byte_ready;
    assign wrap    = byte_hs & (ptr == PTR_LAST);

    always_comb begin
        blk_ready = 1'b0;
        case (state)
            ST_RUN:   blk_ready = pend & (~cur_v | ~nxt_v);
            ST_FLUSH: blk_ready = 1'b1;
            default:  blk_ready = 1'b0;
        endcase
    end

    assign blk_acc = blk_valid & blk_ready;

    // A request is never issued alongside stop, so nothing is left in flight on the way to IDLE
    assign squeeze_req = in_run & ~pend & ~nxt_v & ~stop;

    // Occupancy of CUR once this edge's wrap has retired it; decides where an incoming block lands
    assign cur_after_v = wrap ? nxt_v : cur_v;

    assign cur_din   = (wrap & nxt_v) ? nxt_data : blk_data;
    assign cur_load  = in_run & ~stop & ((wrap & nxt_v) | (blk_acc & ~cur_after_v));
    assign cur_clear = start_idle | stop_run | wrap;
    assign nxt_load  = in_run & ~stop & blk_acc & cur_after_v;
    assign nxt_clear = start_idle | stop_run | wrap;

    squeeze_block_slot #(
        .RATE_BYTES(RATE_BYTES)
    ) u_cur_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (cur_load),
        .clear (cur_clear),
        .din   (cur_din),
        .dout  (cur_data),
        .valid (cur_v)
    );

    squeeze_block_slot #(
        .RATE_BYTES(RATE_BYTES)
    ) u_nxt_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (nxt_load),
        .clear (nxt_clear),
        .din   (blk_data),
        .dout  (nxt_data),
        .valid (nxt_v)
    );

    // FLUSH exists only to swallow the block answering a request that was in flight at stop
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pend  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        pend  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= (pend & ~blk_acc) ? ST_FLUSH : ST_IDLE;
                        pend  <= pend & ~blk_acc;
                    end else if (squeeze_req) begin
                        pend <= 1'b1;
                    end else if (blk_acc) begin
                        pend <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (blk_acc) begin
                        state <= ST_IDLE;
                        pend  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    pend  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            byte_count <= '0;
        end else if (start_idle) begin
            ptr        <= '0;
            byte_count <= '0;
        end else begin
            if (byte_hs && (byte_count != {CNT_W{1'b1}})) begin
                byte_count <= byte_count + 1'b1;
            end
            if (stop_run || wrap) begin
                ptr <= '0;
            end else if (byte_hs) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shake_squeeze_byte_stream.sv
// Directed bench for the squeeze byte stream: a small Keccak responder model
// feeds blocks, and a byte scoreboard checks every consumed byte.
module tb_shake_squeeze_byte_stream;

    localparam int RATE  = 136;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic              squeeze_req;
    logic              blk_valid;
    logic              blk_ready;
    logic [RATE*8-1:0] blk_data;
    logic              byte_valid;
    logic              byte_ready;
    logic [7:0]        byte_data;
    logic              busy;
    logic [CNT_W-1:0]  byte_count;

    always #5 clk = ~clk;

    shake_squeeze_byte_stream #(
        .RATE_BYTES(RATE),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .squeeze_req(squeeze_req),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_data   (blk_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_data  (byte_data),
        .busy       (busy),
        .byte_count (byte_count)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         req_cycles[$];
    int         acc_cycles[$];

    // Keccak responder model
    bit model_busy = 0;
    bit model_present = 0;
    int model_cnt = 0;
    int model_lat = 2;
    int blk_id = 0;
    int cur_blk = 0;

    bit         drop_next = 0;
    bit         tb_running = 0;
    int         hs_total = 0;
    int         double_req = 0;
    bit         gap_watch = 0;
    int         gap_count = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data = 8'h00;

    function automatic logic [7:0] genByte(input int n, input int k);
        if (n == 0) return 8'(k);
        if (n == 1) return 8'(k | 'h80);
        return 8'(k * 3 + n * 29);
    endfunction

    function automatic logic [RATE*8-1:0] genBlock(input int n);
        logic [RATE*8-1:0] b;
        b = '0;
        for (int k = 0; k < RATE; k++) b[8*k +: 8] = genByte(n, k);
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock: present model outputs, resolve handshakes before the edge, advance the model after it
    task automatic applyStimulus();
        logic [7:0] e;
        blk_valid = model_present;
        #1;
        if (prev_stall) begin
            checkOutput("stall_valid", 32'(byte_valid), 32'd1);
            checkOutput("stall_data", 32'(byte_data), 32'(prev_data));
        end
        if (gap_watch && !byte_valid) gap_count++;
        if (byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("byte_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("byte_data", 32'(byte_data), 32'(e));
            end
            got_q.push_back(byte_data);
            hs_total++;
        end
        if (blk_valid && blk_ready) begin
            acc_cycles.push_back(cycle);
            if (!(drop_next || (stop && tb_running)))
                for (int k = 0; k < RATE; k++) exp_q.push_back(genByte(cur_blk, k));
            drop_next     = 0;
            model_busy    = 0;
            model_present = 0;
        end
        if (squeeze_req) begin
            req_cycles.push_back(cycle);
            if (model_busy) double_req++;
            model_busy = 1;
            model_cnt  = model_lat;
        end
        if (stop && tb_running) begin
            exp_q.delete();
            drop_next  = model_busy;
            tb_running = 0;
        end else if (start && !tb_running && !drop_next) begin
            tb_running = 1;
        end
        if (rst) begin
            exp_q.delete();
            model_busy    = 0;
            model_present = 0;
            drop_next     = 0;
            tb_running    = 0;
        end
        prev_stall = byte_valid && !byte_ready && !stop && !rst;
        prev_data  = byte_data;
        @(negedge clk);
        cycle++;
        start = 1'b0;
        stop  = 1'b0;
        if (model_busy && !model_present) begin
            if (model_cnt == 0) begin
                model_present = 1;
                cur_blk       = blk_id;
                blk_id++;
                blk_data      = genBlock(cur_blk);
            end else begin
                model_cnt--;
            end
        end
    endtask

    task automatic consumeBytes(input int n, input bit toggle);
        int target;
        int guard;
        target = hs_total + n;
        guard  = 0;
        while (hs_total < target && guard < 4000) begin
            byte_ready = toggle ? ((guard % 4 == 0) || (guard % 4 == 3)) : 1'b1;
            guard++;
            applyStimulus();
        end
        byte_ready = 1'b0;
        checkOutput("consume_count", 32'(hs_total), 32'(target));
    endtask

    task automatic waitByteValid(input string tag);
        int guard;
        guard = 0;
        while (!byte_valid && guard < 400) begin
            guard++;
            applyStimulus();
        end
        checkOutput(tag, 32'(byte_valid), 32'd1);
    endtask

    task automatic waitIdle(input string tag);
        int guard;
        guard = 0;
        while (busy && guard < 400) begin
            guard++;
            applyStimulus();
        end
        checkOutput(tag, 32'(busy), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_squeeze_req"}, 32'(squeeze_req), 32'd0);
        checkOutput({tag, "_blk_ready"}, 32'(blk_ready), 32'd0);
        checkOutput({tag, "_byte_count"}, 32'(byte_count), 32'd0);
        checkOutput({tag, "_byte_data"}, 32'(byte_data), 32'd0);
    endtask

    initial begin
        logic [CNT_W-1:0] saved_count;
        logic [7:0]       saved_data;

        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        byte_ready = 1'b0;
        blk_valid  = 1'b0;
        blk_data   = '0;

        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        checkAllZero("reset");

        $display("[TB] scenario 1/2: single request, back-to-back blocks");
        model_lat = 2;
        req_cycles.delete();
        acc_cycles.delete();
        got_q.delete();
        start = 1'b1;
        applyStimulus();
        checkOutput("s1_busy", 32'(busy), 32'd1);
        checkOutput("s1_req_after_start", 32'(squeeze_req), 32'd1);
        byte_ready = 1'b1;
        waitByteValid("s1_first_valid");
        checkOutput("s1_one_req_before_accept", 32'(req_cycles.size()), 32'd1);
        checkOutput("s1_req_after_accept", 32'(squeeze_req), 32'd1);
        gap_watch = 1;
        consumeBytes(137, 1'b0);
        gap_watch = 0;
        checkOutput("s2_no_gap", 32'(gap_count), 32'd0);
        checkOutput("s2_byte_count", 32'(byte_count), 32'd137);
        checkOutput("s2_byte135", 32'(got_q[135]), 32'h87);
        checkOutput("s2_byte136", 32'(got_q[136]), 32'h80);
        checkOutput("s1_second_req_cycle", 32'(req_cycles[1]), 32'(acc_cycles[0] + 1));

        $display("[TB] scenario 3: stalled consumer");
        consumeBytes(40, 1'b1);
        checkOutput("s3_byte_count", 32'(byte_count), 32'd177);
        stop = 1'b1;
        applyStimulus();
        waitIdle("s3_idle");

        $display("[TB] scenario 4: stop with request in flight");
        model_lat = 1;
        start = 1'b1;
        applyStimulus();
        waitByteValid("s4_first_valid");
        model_lat = 200;
        consumeBytes(40, 1'b0);
        stop = 1'b1;
        applyStimulus();
        checkOutput("s4_valid_low", 32'(byte_valid), 32'd0);
        checkOutput("s4_flush_busy", 32'(busy), 32'd1);
        checkOutput("s4_flush_blk_ready", 32'(blk_ready), 32'd1);
        checkOutput("s4_flush_no_req", 32'(squeeze_req), 32'd0);
        checkOutput("s4_byte_count", 32'(byte_count), 32'd40);
        waitIdle("s4_idle");
        checkOutput("s4_idle_valid", 32'(byte_valid), 32'd0);
        model_lat = 1;
        start = 1'b1;
        applyStimulus();
        waitByteValid("s4_restart_valid");
        checkOutput("s4_fresh_byte0", 32'(byte_data), 32'(genByte(blk_id - 1, 0)));

        $display("[TB] scenario 5: reset mid-stream");
        consumeBytes(100, 1'b0);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkAllZero("s5_reset");
        blk_id = 0;
        req_cycles.delete();
        acc_cycles.delete();
        start = 1'b1;
        applyStimulus();
        checkOutput("s5_req_after_start", 32'(squeeze_req), 32'd1);
        waitByteValid("s5_first_valid");
        checkOutput("s5_byte0", 32'(byte_data), 32'h00);
        checkOutput("s5_one_req", 32'(req_cycles.size()), 32'd1);
        consumeBytes(10, 1'b0);
        checkOutput("s5_byte_count", 32'(byte_count), 32'd10);

        $display("[TB] scenario 6: ignored start and stop");
        for (int i = 0; i < 10; i++) applyStimulus();
        saved_count = byte_count;
        saved_data  = byte_data;
        start = 1'b1;
        applyStimulus();
        checkOutput("s6_start_count", 32'(byte_count), 32'(saved_count));
        checkOutput("s6_start_data", 32'(byte_data), 32'(saved_data));
        checkOutput("s6_start_valid", 32'(byte_valid), 32'd1);
        checkOutput("s6_start_busy", 32'(busy), 32'd1);
        checkOutput("s6_start_no_req", 32'(squeeze_req), 32'd0);
        stop = 1'b1;
        applyStimulus();
        checkOutput("s6_stop_idle", 32'(busy), 32'd0);
        stop = 1'b1;
        applyStimulus();
        checkOutput("s6_idle_stop_busy", 32'(busy), 32'd0);
        checkOutput("s6_idle_stop_req", 32'(squeeze_req), 32'd0);
        checkOutput("s6_idle_stop_count", 32'(byte_count), 32'(saved_count));
        checkOutput("s6_idle_stop_blk_ready", 32'(blk_ready), 32'd0);

        checkOutput("no_double_request", 32'(double_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shake_squeeze_byte_stream.md
Name: shake_squeeze_byte_stream

Overview:
Converts SHAKE256 squeeze output (full rate blocks from the Keccak core) into a 1-byte-per-cycle valid/ready stream for the SampleInBall rejection sampler. The sampler takes bytes 0..7 as sign bits and the remaining bytes as rejection candidates. The block sits directly upstream of the sampler, between it and the Keccak permutation core. It requests further permutations on demand and holds one prefetched block so the byte stream has no bubble at block boundaries.

Parameters:
RATE_BYTES, 136, squeeze block size in bytes (136 = SHAKE256, 168 = SHAKE128)
CNT_W, 16, width of emitted-byte counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begin new stream (accepted only in IDLE)
stop  in  1  pulse; consumer finished, abandon stream
squeeze_req  out  1  one-cycle pulse to Keccak core: produce next rate block
blk_valid  in  1  rate block available
blk_ready  out  1  block accepted when blk_valid & blk_ready
blk_data  in  RATE_BYTES*8  rate block, byte k = blk_data[8k+7:8k]
byte_valid  out  1  byte_data valid
byte_ready  in  1  consumer accepts byte
byte_data  out  8  current stream byte
busy  out  1  high in any state other than IDLE
byte_count  out  CNT_W  bytes transferred since start, saturating

Behaviour:
- Storage: two block slots, CUR and NXT, each with a valid flag. Byte pointer ptr (0..RATE_BYTES-1) into CUR. Flag pend marks a squeeze request in flight.
- Reset: all outputs 0, both slot flags 0, ptr=0, pend=0, byte_count=0, state IDLE. Reset mid-operation discards everything immediately. An in-flight Keccak block is the core's concern; the core is reset together with this block.
- FSM states: IDLE, RUN, FLUSH.
- IDLE, start=1: go to RUN, clear slots, ptr and byte_count, and assert squeeze_req the next cycle (pend=1).
- RUN:
  - blk_ready = pend & (!CUR.v | !NXT.v).
  - An accepted block goes to CUR if CUR is empty, else to NXT. pend clears on acceptance.
  - squeeze_req pulses for one cycle when !pend and NXT is empty. Never two requests outstanding.
  - byte_valid = CUR.v; byte_data = CUR byte[ptr] (mux from registers, no extra latency).
  - Each handshake (byte_valid & byte_ready) increments ptr and byte_count (saturate at all-ones).
  - At ptr = RATE_BYTES-1 the handshake wraps ptr to 0. On the same edge, CUR takes NXT contents if NXT.v, else CUR.v clears.
  - Block accepted cycle t with CUR empty: byte_valid high at cycle t+1.
  - With NXT already filled, the byte after byte RATE_BYTES-1 is valid on the very next cycle (zero bubble).
  - Wrap and block acceptance on the same edge: NXT→CUR shift happens, and the incoming block lands in the freed NXT.
- stop in RUN: slots and byte_valid clear the next cycle.
  - If pend=1, go to FLUSH. FLUSH holds blk_ready=1, discards the next accepted block, then goes to IDLE.
  - Otherwise go to IDLE.
- stop and a byte handshake in the same cycle: the handshake counts, then stop applies.
- start outside IDLE is ignored. stop in IDLE or FLUSH is ignored.
- byte_valid, once asserted, holds and byte_data stays stable until the handshake, stop, or rst.

Decomposition:
- Shared package dilithium_pkg holds:
  - SHAKE128_RATE_BYTES=168, SHAKE256_RATE_BYTES=136
  - FSM state enum (IDLE/RUN/FLUSH)
  - tau/level constants already used by SampleInBall
- One sub-module is natural: squeeze_block_slot. It is a RATE_BYTES-wide register with valid flag, load and clear, instantiated twice. The byte mux stays in the top.

Test Plan:
1. start; Keccak returns block with byte k = k (0x00..0x87) → byte_data 0x00,0x01,…,0x87 on consecutive cycles with byte_ready=1; exactly one squeeze_req after start, second squeeze_req one cycle after first block accepted.
2. Two blocks (second block byte k = 0x80|k mod 256) with immediate blk_valid → byte 135=0x87 followed next cycle by 0x80, no byte_valid gap; byte_count=137 after 137 handshakes.
3. byte_ready toggled 1,0,0,1 pattern → byte_data stable while stalled, no byte skipped or duplicated, byte_count equals handshake count.
4. stop at ptr=40 with pend=1 → byte_valid low next cycle, state FLUSH, next blk_valid accepted and dropped, then IDLE; new start yields first byte of a freshly requested block.
5. rst asserted at ptr=100 in RUN → next cycle all outputs 0, busy=0; start afterwards behaves as scenario 1.
6. start pulsed while busy, and stop pulsed in IDLE → no state, counter or squeeze_req change.
